target_lut_prog: RTL and testbench
==================================

// Module: target_lut_prog
// PURPOSE
//  Programmable branch-target lookup table; parametrised successor to the fixed PC-target LUT.
//  Maps a short jump pointer (from an instruction field) to a full-width PC target.
//  Entries are written at run time and carry valid bits. Reads are registered.
//  A self-clearing init sequencer runs after reset and on Flush. A saturating miss counter is provided.
//  Sits between instruction decode and the PC/fetch unit.
// PARAMETERS
//  ADDR_W  4   pointer width; DEPTH = 2**ADDR_W entries
//  TGT_W   10  PC target width
//  CNT_W   8   miss counter width (saturating)
// PORTS
//  Clk      in   1       clock; all state updates on posedge
//  Reset    in   1       synchronous, active-high reset
//  Flush    in   1       restart init sequence (clears all entries)
//  WrEn     in   1       write strobe
//  WrAddr   in   ADDR_W  entry to write
//  WrData   in   TGT_W   target value to store
//  RdEn     in   1       lookup request
//  RdAddr   in   ADDR_W  entry to look up
//  Target   out  TGT_W   registered lookup result
//  Hit      out  1       registered: entry was valid
//  RdValid  out  1       one-cycle pulse; Target/Hit are updated this cycle
//  Busy     out  1       1 while init sequencer is running (state INIT)
//  MissCnt  out  CNT_W   count of reads with Hit=0; saturates at all-ones
// BEHAVIOUR
//  Reset (sync): state=INIT, init counter=0, Target=0, Hit=0, RdValid=0, MissCnt=0. Busy=1 from that edge.
//  State INIT:
//   - Each cycle: entry[cnt] <= {valid=0, target=0}; cnt++.
//   - At cnt==DEPTH-1: that entry is cleared, then state goes to READY.
//   - Busy is high for exactly DEPTH cycles after Reset/Flush is released.
//   - WrEn and RdEn are ignored. RdValid=0. Target and Hit hold their values.
//  State READY:
//   - WrEn=1: entry[WrAddr] <= {1, WrData} at the edge.
//   - RdEn=1: on the next edge, Target=entry[RdAddr].target, Hit=entry[RdAddr].valid, RdValid=1. Latency is 1 cycle.
//   - RdEn=0: RdValid=0; Target and Hit hold.
//   - Invalid entry read: Target=0, Hit=0.
//   - Write and read in the same cycle, same address: write-first. Target=WrData, Hit=1.
//   - Write and read in the same cycle, different addresses: the two operations are independent.
//  Flush=1 (any state): next state INIT, cnt=0, MissCnt=0, RdValid=0.
//   - A WrEn or RdEn in the same cycle is dropped.
//   - Flush during INIT restarts the sequence at entry 0.
//  Priority: Reset > Flush > normal operation. Reset mid-INIT restarts the sequence from 0.
//  MissCnt: increments on each RdValid with Hit=0. Holds at 2**CNT_W-1; never wraps.
//  Address ranges: all ADDR_W values are legal (DEPTH is a power of 2), so no out-of-range case exists.
//  Outputs depend only on registered state; there is no combinational path from inputs to outputs.
// TESTING
//  1. Reset 1 cycle, then idle. Busy=1 for 16 cycles, then 0. Target=0, Hit=0, MissCnt=0.
//  2. After init: write addr 3 = 10'h1C0, then read addr 3. Next cycle: Target=10'h1C0, Hit=1, RdValid=1.
//  3. Read never-written addr 9. Result: Target=0, Hit=0. MissCnt goes 0 -> 1.
//  4. Same cycle: write addr 5 = 10'h200 and read addr 5. Next cycle: Target=10'h200, Hit=1.
//  5. Write addr 2 = 10'h1B7, then Flush with WrEn set in the same cycle. Result: Busy for 16 cycles,
//     read addr 2 returns Hit=0, MissCnt restarts from 0.
//  6. Assert Reset mid-INIT at cnt=7. Busy stays high 16 more cycles. 300 misses give MissCnt=255 (saturated).

Source files
------------

// File: rtl/target_lut_prog_if.sv
// Bus between decode/fetch and the branch-target LUT: program, look up, flush.
interface target_lut_prog_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned TGT_W  = 10,
  parameter int unsigned CNT_W  = 8
);
  logic              Flush;
  logic              WrEn;
  logic [ADDR_W-1:0] WrAddr;
  logic [TGT_W-1:0]  WrData;
  logic              RdEn;
  logic [ADDR_W-1:0] RdAddr;
  logic [TGT_W-1:0]  Target;
  logic              Hit;
  logic              RdValid;
  logic              Busy;
  logic [CNT_W-1:0]  MissCnt;

  modport master (
    output Flush, WrEn, WrAddr, WrData, RdEn, RdAddr,
    input  Target, Hit, RdValid, Busy, MissCnt
  );

  modport slave (
    input  Flush, WrEn, WrAddr, WrData, RdEn, RdAddr,
    output Target, Hit, RdValid, Busy, MissCnt
  );
endinterface

// File: rtl/target_lut_prog.sv
// Programmable branch-target LUT: jump pointer -> PC target, with valid bits,
// registered lookups, a self-clearing init sequencer and a saturating miss counter.
module target_lut_prog #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned TGT_W  = 10,
  parameter int unsigned CNT_W  = 8
) (
  input logic              Clk,
  input logic              Reset,
  target_lut_prog_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] init_cnt, init_cnt_next;

  logic [TGT_W-1:0]  tgt_mem [DEPTH];
  logic [DEPTH-1:0]  vld;

  logic              wr_go, rd_go, rd_bypass, rd_hit;
  logic [TGT_W-1:0]  rd_tgt;

  logic [TGT_W-1:0]  target_q;
  logic              hit_q, rd_valid_q;
  logic [CNT_W-1:0]  miss_q;

  // State and init-counter register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_next;
      init_cnt <= init_cnt_next;
    end
  end

  // Next-state logic and operation qualification
  always_comb begin
    state_next    = state;
    init_cnt_next = init_cnt;
    wr_go         = 1'b0;
    rd_go         = 1'b0;
    if (bus.Flush) begin
      state_next    = ST_INIT;
      init_cnt_next = '0;
    end else begin
      case (state)
        ST_INIT: begin
          init_cnt_next = init_cnt + 1'b1;
          if (init_cnt == ADDR_W'(DEPTH - 1)) state_next = ST_READY;
        end
        ST_READY: begin
          wr_go = bus.WrEn;
          rd_go = bus.RdEn;
        end
        default: state_next = ST_INIT;
      endcase
    end
  end

  // Lookup data, write-first when a write targets the entry being read
  always_comb begin
    rd_bypass = wr_go && (bus.WrAddr == bus.RdAddr);
    rd_hit    = rd_bypass || vld[bus.RdAddr];
    if (rd_bypass)             rd_tgt = bus.WrData;
    else if (vld[bus.RdAddr])  rd_tgt = tgt_mem[bus.RdAddr];
    else                       rd_tgt = '0;
  end

  // Entry storage: cleared one entry per cycle during init, written when ready
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (state == ST_INIT && !bus.Flush) begin
        tgt_mem[init_cnt] <= '0;
        vld[init_cnt]     <= 1'b0;
      end else if (wr_go) begin
        tgt_mem[bus.WrAddr] <= bus.WrData;
        vld[bus.WrAddr]     <= 1'b1;
      end
    end
  end

  // Registered lookup result and saturating miss counter
  always_ff @(posedge Clk) begin
    if (Reset) begin
      target_q   <= '0;
      hit_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      miss_q     <= '0;
    end else begin
      rd_valid_q <= rd_go;
      if (rd_go) begin
        target_q <= rd_tgt;
        hit_q    <= rd_hit;
      end
      if (bus.Flush)                            miss_q <= '0;
      else if (rd_go && !rd_hit && miss_q != '1) miss_q <= miss_q + 1'b1;
    end
  end

  assign bus.Target  = target_q;
  assign bus.Hit     = hit_q;
  assign bus.RdValid = rd_valid_q;
  assign bus.Busy    = (state == ST_INIT);
  assign bus.MissCnt = miss_q;
endmodule

// File: tb/tb_target_lut_prog.sv
// Scoreboard bench for target_lut_prog: directed scenarios plus random traffic
// against a table-level reference model.
module tb_target_lut_prog;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned TGT_W  = 10;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned CMAX   = 255;

  typedef struct {
    int unsigned tgt;
    int unsigned hit;
    int unsigned miss;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset;
  int   total = 0;
  int   bad   = 0;

  target_lut_prog_if #(.ADDR_W(ADDR_W), .TGT_W(TGT_W), .CNT_W(CNT_W)) bus ();

  target_lut_prog #(.ADDR_W(ADDR_W), .TGT_W(TGT_W), .CNT_W(CNT_W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 Clk = ~Clk;

  // Reference model: table contents, remaining busy cycles, miss count
  int unsigned m_tgt [DEPTH];
  bit          m_vld [DEPTH];
  int unsigned busy_left = DEPTH;
  int unsigned m_miss    = 0;
  bit          busy_chk  = 1'b0;
  exp_t        sb [$];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every RdValid pulse is matched against the next scoreboard entry
  always @(negedge Clk) begin
    if (bus.RdValid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_rdvalid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("target", bus.Target, e.tgt);
        check("hit", bus.Hit, e.hit);
        check("misscnt", bus.MissCnt, e.miss);
      end
    end
  end

  // One clock: drive inputs, check Busy, advance model; returns just after the next negedge
  task automatic step(input bit rst, input bit fl, input bit we, input int unsigned wa,
                      input int unsigned wd, input bit re, input int unsigned ra);
    Reset      = rst;
    bus.Flush  = fl;
    bus.WrEn   = we;
    bus.WrAddr = ADDR_W'(wa);
    bus.WrData = TGT_W'(wd);
    bus.RdEn   = re;
    bus.RdAddr = ADDR_W'(ra);
    if (busy_chk) check("busy", int'(bus.Busy), int'(busy_left > 0));
    if (rst || fl) begin
      busy_left = DEPTH;
      m_miss    = 0;
      foreach (m_vld[i]) begin
        m_vld[i] = 1'b0;
        m_tgt[i] = 0;
      end
    end else if (busy_left > 0) begin
      busy_left--;
    end else begin
      if (re) begin
        exp_t e;
        if (we && wa == ra) begin
          e.tgt = wd; e.hit = 1;
        end else begin
          e.hit = m_vld[ra];
          e.tgt = m_vld[ra] ? m_tgt[ra] : 0;
        end
        if (e.hit == 0 && m_miss < CMAX) m_miss++;
        e.miss = m_miss;
        sb.push_back(e);
      end
      if (we) begin
        m_vld[wa] = 1'b1;
        m_tgt[wa] = wd;
      end
    end
    @(negedge Clk);
    if (rst) busy_chk = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    Reset = 1'b1;
    bus.Flush = 0; bus.WrEn = 0; bus.WrAddr = '0; bus.WrData = '0;
    bus.RdEn = 0; bus.RdAddr = '0;
    @(negedge Clk);
    // Reset then idle through init
    step(1, 0, 0, 0, 0, 0, 0);
    check("rst_target", bus.Target, 0);
    check("rst_hit", bus.Hit, 0);
    check("rst_rdvalid", bus.RdValid, 0);
    check("rst_misscnt", bus.MissCnt, 0);
    idle(18);
    // Write then read, miss on unwritten entry, same-cycle write/read bypass
    step(0, 0, 1, 3, 'h1C0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 3);
    step(0, 0, 0, 0, 0, 1, 9);
    step(0, 0, 1, 5, 'h200, 1, 5);
    step(0, 0, 1, 6, 'h0AA, 1, 3);
    idle(2);
    // Write, then flush with a dropped write; entry must read invalid afterwards
    step(0, 0, 1, 2, 'h1B7, 0, 0);
    step(0, 1, 1, 2, 'h3FF, 1, 2);
    idle(16);
    step(0, 0, 0, 0, 0, 1, 2);
    idle(2);
    // Flush during init restarts it
    step(0, 1, 0, 0, 0, 0, 0);
    idle(5);
    step(0, 1, 0, 0, 0, 0, 0);
    idle(17);
    // Reset mid-init at count 7, then saturate the miss counter
    step(0, 1, 0, 0, 0, 0, 0);
    idle(7);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(17);
    for (int i = 0; i < 300; i++) step(0, 0, 0, 0, 0, 1, $urandom_range(0, DEPTH - 1));
    idle(2);
    check("miss_saturated", bus.MissCnt, CMAX);
    // Random traffic with occasional flush/reset
    for (int i = 0; i < 1500; i++) begin
      int unsigned r;
      r = $urandom_range(0, 999);
      step(r < 3, (r >= 3 && r < 12), $urandom_range(0, 2) == 0, $urandom_range(0, DEPTH - 1),
           $urandom_range(0, 1023), $urandom_range(0, 1) == 1, $urandom_range(0, DEPTH - 1));
    end
    idle(3);
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
